// File: rtl/cam_manager_pkg.sv
// Shared encodings for the CAM command controller: FSM states, response status and command opcodes.
package cam_manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_DECIDE,
    ST_WRITE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] RSP_OK        = 2'd0;
  localparam logic [1:0] RSP_EXISTS    = 2'd1;
  localparam logic [1:0] RSP_FULL      = 2'd2;
  localparam logic [1:0] RSP_NOT_FOUND = 2'd3;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

endpackage

// File: rtl/cam_free_encoder.sv
// Lowest-clear-bit priority encoder over the entry valid bitmap; purely combinational.
module cam_free_encoder #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] bitmap,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic                       none_free
);

  always_comb begin
    addr      = '0;
    none_free = &bitmap;
    // Scan downward so the last assignment wins with the lowest free index.
    for (int i = (1 << ADDR_WIDTH) - 1; i >= 0; i--) begin
      if (!bitmap[i]) addr = ADDR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/cam_manager.sv
// Insert/delete controller owning a CAM's write and compare ports; one command in flight,
// response after MATCH_LATENCY+2 cycles minimum, new commands held off until the response is taken.
module cam_manager
  import cam_manager_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 5,
  parameter int MATCH_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  full
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  state_t                  state, state_nxt;
  logic                    op_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [1:0]              lat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              status_q;
  logic [ENTRIES-1:0]      bitmap;
  logic [ADDR_WIDTH:0]     count_q;
  logic                    wait_first;
  logic [ADDR_WIDTH-1:0]   free_addr;
  logic                    none_free;
  logic                    no_room;
  logic                    decide_write;
  logic                    accept;

  cam_free_encoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_enc (
    .bitmap    (bitmap),
    .addr      (free_addr),
    .none_free (none_free)
  );

  assign full         = (count_q == (ADDR_WIDTH+1)'(ENTRIES));
  assign no_room      = full | none_free;
  assign decide_write = (op_q == OP_INSERT) ? (!cam_match && !no_room) : cam_match;
  assign accept       = cmd_valid & cmd_ready;

  assign entry_count      = count_q;
  assign rsp_status       = status_q;
  assign rsp_addr         = addr_q;
  assign cam_compare_data = key_q;
  assign cam_write_data   = key_q;
  assign cam_write_addr   = addr_q;
  assign cam_write_delete = op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;
    cam_write_enable = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Ready is masked while reset is held so the port reads idle-but-closed.
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (lat_cnt == 2'd0) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        state_nxt = decide_write ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        if (!cam_write_busy) begin
          cam_write_enable = 1'b1;
          state_nxt        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Busy may only rise the cycle after enable, so the first WAIT cycle never exits.
        if (!wait_first && !cam_write_busy) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 1'b0;
      key_q      <= '0;
      lat_cnt    <= '0;
      addr_q     <= '0;
      status_q   <= RSP_OK;
      bitmap     <= '0;
      count_q    <= '0;
      wait_first <= 1'b0;
    end else begin
      wait_first <= cam_write_enable;
      if (accept) begin
        op_q    <= cmd_op;
        key_q   <= cmd_data;
        lat_cnt <= 2'(MATCH_LATENCY - 1);
      end
      if (state == ST_LOOKUP && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (state == ST_DECIDE) begin
        if (op_q == OP_INSERT) begin
          if (cam_match) begin
            status_q <= RSP_EXISTS;
            addr_q   <= cam_match_addr;
          end else if (no_room) begin
            status_q <= RSP_FULL;
            addr_q   <= '0;
          end else begin
            status_q <= RSP_OK;
            addr_q   <= free_addr;
          end
        end else if (cam_match) begin
          status_q <= RSP_OK;
          addr_q   <= cam_match_addr;
        end else begin
          status_q <= RSP_NOT_FOUND;
          addr_q   <= '0;
        end
      end
      if (cam_write_enable) begin
        bitmap[addr_q] <= (op_q == OP_INSERT);
        if (op_q == OP_INSERT) count_q <= count_q + (ADDR_WIDTH+1)'(1);
        else                   count_q <= count_q - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_manager.sv
// Randomised scoreboard bench for cam_manager with a behavioural CAM and a key-table reference model.
module tb_cam_manager;

  localparam int DW = 64;
  localparam int AW = 2;
  localparam int ML = 2;
  localparam int N  = 1 << AW;

  localparam logic [1:0] S_OK     = 2'd0;
  localparam logic [1:0] S_EXISTS = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_NF     = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;
  logic [AW:0]   entry_count;
  logic          full;

  always #5 clk = ~clk;

  cam_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(ML)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .entry_count(entry_count), .full(full)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Behavioural CAM: contents cleared by the shared reset, ML-cycle match pipeline, random busy tail.
  logic [DW-1:0] cam_key [N];
  logic          cam_vld [N];
  logic [ML-1:0] m_pipe;
  logic [AW-1:0] a_pipe [ML];
  logic          hit_c;
  logic [AW-1:0] hit_addr_c;
  int            busy_cnt;
  logic          busy_force = 1'b0;

  always_comb begin
    hit_c      = 1'b0;
    hit_addr_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
        hit_c      = 1'b1;
        hit_addr_c = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cam_vld[i] <= 1'b0;
        cam_key[i] <= '0;
      end
      m_pipe <= '0;
      for (int i = 0; i < ML; i++) a_pipe[i] <= '0;
    end else begin
      if (cam_write_enable) begin
        cam_vld[cam_write_addr] <= !cam_write_delete;
        cam_key[cam_write_addr] <= cam_write_data;
      end
      m_pipe[0] <= hit_c;
      a_pipe[0] <= hit_addr_c;
      for (int i = 1; i < ML; i++) begin
        m_pipe[i] <= m_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
      end
    end
  end

  assign cam_match      = m_pipe[ML-1];
  assign cam_match_addr = a_pipe[ML-1];

  always @(posedge clk or posedge rst) begin
    if (rst)                   busy_cnt <= 0;
    else if (cam_write_enable) busy_cnt <= $urandom_range(0, 3);
    else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
  end
  assign cam_write_busy = busy_force || (busy_cnt != 0);

  // Reference model: a table of stored keys, searched and updated from the command rules.
  typedef struct {
    logic [1:0]    st;
    logic [AW-1:0] addr;
    int            cnt;
    bit            wr;
    int            t_acc;
  } rsp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          del;
  } wr_t;

  rsp_t          exp_rsp_q[$];
  wr_t           exp_wr_q[$];
  logic [DW-1:0] ref_key [N];
  bit            ref_vld [N];

  task automatic ref_clear();
    for (int i = 0; i < N; i++) begin
      ref_vld[i] = 1'b0;
      ref_key[i] = '0;
    end
    exp_rsp_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic model_cmd(input logic op, input logic [DW-1:0] key);
    int   hit, fr, c;
    rsp_t r;
    wr_t  w;
    hit = -1;
    fr  = -1;
    for (int i = 0; i < N; i++) begin
      if (ref_vld[i] && ref_key[i] == key && hit < 0) hit = i;
      if (!ref_vld[i] && fr < 0) fr = i;
    end
    r.wr = 1'b0;
    r.addr = '0;
    r.t_acc = cyc;
    if (op == 1'b0) begin
      if (hit >= 0) begin
        r.st = S_EXISTS; r.addr = AW'(hit);
      end else if (fr >= 0) begin
        r.st = S_OK; r.addr = AW'(fr); r.wr = 1'b1;
        ref_vld[fr] = 1'b1; ref_key[fr] = key;
      end else begin
        r.st = S_FULL;
      end
    end else begin
      if (hit >= 0) begin
        r.st = S_OK; r.addr = AW'(hit); r.wr = 1'b1;
        ref_vld[hit] = 1'b0;
      end else begin
        r.st = S_NF;
      end
    end
    if (r.wr) begin
      w.addr = r.addr; w.data = key; w.del = op;
      exp_wr_q.push_back(w);
    end
    c = 0;
    for (int i = 0; i < N; i++) if (ref_vld[i]) c++;
    r.cnt = c;
    exp_rsp_q.push_back(r);
  endtask

  // Write-port monitor.
  bit prev_en = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (cam_write_enable) begin
        check("write_while_busy", cam_write_busy, 1'b0);
        check("write_enable_single_pulse", prev_en, 1'b0);
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h del %0b, expected no write",
                   cam_write_addr, cam_write_data, cam_write_delete);
        end else begin
          check("write_addr",   cam_write_addr,   exp_wr_q[0].addr);
          check("write_data",   cam_write_data,   exp_wr_q[0].data);
          check("write_delete", cam_write_delete, exp_wr_q[0].del);
          if (cam_write_delete) check("delete_of_unset_entry", cam_vld[cam_write_addr], 1'b1);
          void'(exp_wr_q.pop_front());
        end
      end
      prev_en = cam_write_enable;
    end
  end

  // Response monitor.
  rsp_t          cur;
  bit            rsp_seen = 1'b0;
  logic [1:0]    held_st;
  logic [AW-1:0] held_addr;
  always @(negedge clk) begin
    if (rst) begin
      rsp_seen = 1'b0;
    end else if (rsp_valid) begin
      check("cmd_ready_low_in_resp", cmd_ready, 1'b0);
      if (!rsp_seen) begin
        if (exp_rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got status %0d addr %0d, expected no response", rsp_status, rsp_addr);
        end else begin
          cur = exp_rsp_q[0];
          check("rsp_status", rsp_status, cur.st);
          check("rsp_addr",   rsp_addr,   cur.addr);
          if (!cur.wr) check("rsp_latency", cyc - cur.t_acc, ML + 2);
        end
        rsp_seen  = 1'b1;
        held_st   = rsp_status;
        held_addr = rsp_addr;
      end else begin
        check("rsp_status_stable", rsp_status, held_st);
        check("rsp_addr_stable",   rsp_addr,   held_addr);
      end
      if (rsp_ready) begin
        if (exp_rsp_q.size() != 0) begin
          check("entry_count", entry_count, cur.cnt);
          check("full_flag",   full,        cur.cnt == N);
          void'(exp_rsp_q.pop_front());
        end
        rsp_seen = 1'b0;
      end
    end
  end

  bit hold_rdy = 1'b0;
  always @(posedge clk) begin
    #2;
    rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic op, input logic [DW-1:0] key);
    int n;
    n = 0;
    cmd_op    = op;
    cmd_data  = key;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 300) begin
        timeout("cmd_accept");
        cmd_valid = 1'b0;
        return;
      end
    end
    model_cmd(op, key);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_rsp_q.size() != 0 || !cmd_ready) begin
      n++;
      if (n > 500) begin
        timeout("wait_idle");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    check("rst_cmd_ready",    cmd_ready,        1'b0);
    check("rst_rsp_valid",    rsp_valid,        1'b0);
    check("rst_rsp_status",   rsp_status,       2'd0);
    check("rst_rsp_addr",     rsp_addr,         '0);
    check("rst_wr_addr",      cam_write_addr,   '0);
    check("rst_wr_data",      cam_write_data,   '0);
    check("rst_wr_delete",    cam_write_delete, 1'b0);
    check("rst_wr_enable",    cam_write_enable, 1'b0);
    check("rst_compare_data", cam_compare_data, '0);
    check("rst_entry_count",  entry_count,      '0);
    check("rst_full",         full,             1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    ref_clear();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    send(1'b0, 64'hAA);
    send(1'b0, 64'hBB);
    send(1'b0, 64'hCC);
    send(1'b0, 64'hBB);
    send(1'b0, 64'h11);
    send(1'b0, 64'hDD);
    wait_idle();
    check("full_after_fill", full, 1'b1);
    send(1'b1, 64'hBB);
    send(1'b0, 64'hEE);
    send(1'b1, 64'h99);
    wait_idle();

    // Busy held across a delete: no enable and no response while busy.
    busy_force = 1'b1;
    send(1'b1, 64'hCC);
    repeat (10) begin
      @(negedge clk);
      check("busy_hold_no_enable", cam_write_enable, 1'b0);
      check("busy_hold_no_rsp",    rsp_valid,        1'b0);
    end
    @(posedge clk);
    #1 busy_force = 1'b0;
    wait_idle();

    // Response back-pressure.
    hold_rdy = 1'b1;
    send(1'b0, 64'h55);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) timeout("rsp_under_backpressure");
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clk);
    #1 hold_rdy = 1'b0;
    wait_idle();

    // Reset while parked in WAIT: command abandoned, table emptied.
    send(1'b1, 64'hAA);
    n = 0;
    @(negedge clk);
    while (!cam_write_enable && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cam_write_enable) timeout("enable_before_reset");
    @(posedge clk);
    #1 busy_force = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs();
    ref_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    busy_force = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    send(1'b0, 64'hAB);
    wait_idle();

    for (int k = 0; k < 300; k++) begin
      logic [DW-1:0] key;
      key = {32'hC0DE_0000, 32'($urandom_range(1, 6))};
      send(1'($urandom_range(0, 1)), key);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    check("rsp_queue_drained",   exp_rsp_q.size(), 0);
    check("write_queue_drained", exp_wr_q.size(),  0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_manager.md
Name: cam_manager

Overview:
- Command-level controller sitting in front of one CAM instance. It owns both the CAM write port and the CAM compare port.
- Accepts insert/delete commands over a valid/ready interface and looks each key up first to reject duplicates.
- Allocates free entries from an internal valid bitmap, sequences the CAM write/delete handshake, and returns a status/address response.
- Sits between packet-classification logic and the CAM; user lookups are out of scope.

Parameters:
- DATA_WIDTH, 64, key width; must equal the CAM's DATA_WIDTH.
- ADDR_WIDTH, 5, log2 of CAM entries; must equal the CAM's ADDR_WIDTH.
- MATCH_LATENCY, 1, cycles from compare_data driven to match/match_addr valid; must be 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  1  0=insert, 1=delete
- cmd_data  in  DATA_WIDTH  key
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_status  out  2  0=OK, 1=EXISTS, 2=FULL, 3=NOT_FOUND
- rsp_addr  out  ADDR_WIDTH  entry address (0 for FULL/NOT_FOUND)
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
- cam_write_data  out  DATA_WIDTH  to CAM write_data
- cam_write_delete  out  1  to CAM write_delete
- cam_write_enable  out  1  to CAM write_enable
- cam_write_busy  in  1  from CAM write_busy
- cam_compare_data  out  DATA_WIDTH  to CAM compare_data
- cam_match  in  1  from CAM match
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr (lowest matching index)
- entry_count  out  ADDR_WIDTH+1  number of valid entries
- full  out  1  entry_count == 2**ADDR_WIDTH

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, valid bitmap=0, entry_count=0, full=0.
  - cmd_ready=0, rsp_valid=0, rsp_status=0, rsp_addr=0.
  - All cam_* outputs=0.
  - CAM must share the same rst so its contents clear with the bitmap. Reset mid-operation abandons the command with no response.
- States: IDLE, LOOKUP, DECIDE, WRITE, WAIT, RESP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid, latch op/data, drive cam_compare_data=data (held until next command), load latency counter, go LOOKUP.
- LOOKUP:
  - Count MATCH_LATENCY cycles, then go DECIDE.
  - cam_match/cam_match_addr are sampled in DECIDE.
- DECIDE (one cycle):
  - insert & match: status EXISTS, addr=match_addr → RESP.
  - insert & !match & !full: addr = lowest-index clear bitmap bit (priority encoder), status OK → WRITE.
  - insert & !match & full: status FULL, addr=0 → RESP.
  - delete & match: addr=match_addr, status OK → WRITE.
  - delete & !match: status NOT_FOUND, addr=0 → RESP.
- WRITE:
  - Wait until cam_write_busy=0.
  - Then assert cam_write_enable for exactly one cycle with cam_write_addr=addr, cam_write_data=key, cam_write_delete=op.
  - Same cycle: set (insert) or clear (delete) the bitmap bit, inc/dec entry_count.
  - → WAIT.
- WAIT:
  - The first cycle is always spent (busy may assert one cycle after enable).
  - Thereafter, leave for RESP on the first cycle with cam_write_busy=0.
- RESP:
  - rsp_valid=1 with status/addr stable until rsp_ready.
  - On handshake → IDLE.
  - No new command is accepted until the response is consumed.
- Throughput: one command in flight. Minimum latency accept→rsp_valid (no write) = MATCH_LATENCY+2 cycles.
- cam_write_enable never asserts outside WRITE. entry_count never wraps: insert blocked at full; delete only on match.
- Delete on a key matched by the CAM whose bitmap bit is already clear is an invariant violation; the bench asserts it never occurs.

Decomposition:
- Shared package holds:
  - status encodings RSP_OK, RSP_EXISTS, RSP_FULL, RSP_NOT_FOUND
  - op encodings OP_INSERT, OP_DELETE
  - state encoding
- One sub-module: cam_free_encoder, a parameterised lowest-zero priority encoder over the 2**ADDR_WIDTH bitmap with outputs addr and none_free.

Test Plan:
- Reset, then insert 0xAA, 0xBB, 0xCC (ADDR_WIDTH=2) → OK at addr 0,1,2; entry_count=3; one cam_write_enable pulse each with delete=0.
- Insert 0xBB again → EXISTS, addr=1; no cam_write_enable; entry_count unchanged.
- Fill to 4 entries, then insert 0xDD → FULL, addr=0, full=1; no write.
- Delete 0xBB → OK, addr=1, cam_write_delete=1; then insert 0xEE → OK, addr=1 (lowest free reused). Delete 0x99 → NOT_FOUND.
- Hold cam_write_busy=1 for 10 cycles around a write → enable issued only when busy=0, rsp_valid only after busy falls. Hold rsp_ready=0 for 5 cycles → rsp stable, cmd_ready=0.
- Assert rst during WAIT → all outputs 0 immediately (async); no response; next insert gets addr 0.
